imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the instruction memory for the single-cycle/pipelined core: owns the PC,
//  drives the imem word address, captures the combinational imem read data into a
//  small fetch queue, and presents {pc, inst} to decode with a valid/ready handshake.
//  Handles start/stop (fetch_en) and branch/jump redirects, flushing stale entries.
// PARAMETERS
//  IMEM_ADDR_WIDTH  10        imem word-address width (1024 entries = 4 KB)
//  RESET_PC         32'h0     PC loaded on reset (bits [1:0] must be 0)
//  FQ_DEPTH         2         fetch-queue entries (power of 2, >= 2)
// PORTS
//  clk             in   1                 core clock, all state on rising edge
//  reset_n         in   1                 synchronous reset, active-low
//  fetch_en        in   1                 1 = fetch allowed; 0 = hold PC, no new pushes
//  redirect_valid  in   1                 1-cycle pulse: flush and restart at redirect_pc
//  redirect_pc     in   32                new byte PC (bits [1:0] ignored, forced 0)
//  imem_addr       out  IMEM_ADDR_WIDTH   word address to imem = pc[IMEM_ADDR_WIDTH+1:2]
//  imem_dout       in   32                imem read data (combinational, same cycle)
//  inst_valid      out  1                 queue head valid
//  inst_ready      in   1                 decode accepts head when valid&ready
//  inst_out        out  32                instruction at queue head
//  inst_pc         out  32                byte PC of inst_out
//  fq_count        out  $clog2(FQ_DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): pc<=RESET_PC, queue emptied, state<=IDLE;
//   inst_valid=0, inst_out=0, inst_pc=0, fq_count=0, imem_addr=RESET_PC[IMEM_ADDR_WIDTH+1:2].
//   Reset asserted mid-operation discards all entries at that edge; no partial state kept.
//  FSM: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 (entries kept, drain
//   normally); any state + redirect_valid -> RUN if fetch_en=1 else IDLE, with flush.
//  imem_addr is purely combinational from pc register; PC bits above IMEM_ADDR_WIDTH+1
//   are ignored by imem (address aliases), pc itself is full 32-bit and wraps
//   32'hFFFF_FFFC -> 32'h0000_0000.
//  Push: in RUN, no redirect, and (fq_count<FQ_DEPTH or pop this cycle) -> write
//   {pc, imem_dout} at tail, pc<=pc+4. Otherwise pc holds.
//  Pop: inst_valid & inst_ready -> head advances. Push and pop in the same cycle when
//   full is allowed (count unchanged, zero bubble). Push and pop when empty: new entry is
//   NOT bypassed; it appears on inst_* the next cycle (fetch latency 1 cycle from pc).
//  inst_out/inst_pc/inst_valid are driven from queue storage only (registered).
//  Redirect: highest priority. At the edge: queue emptied (pending pop discarded),
//   pc<={redirect_pc[31:2],2'b00}, no push that cycle; first new instruction is pushed
//   the following cycle and visible the cycle after (2-cycle redirect penalty).
//  Back-to-back redirects: last one wins; each restarts the penalty.
//  inst_valid never drops while inst_ready=0 except on redirect or reset.
//  fq_count in 0..FQ_DEPTH; never over/underflows; read/write pointers wrap mod FQ_DEPTH.
// TESTING
//  1 Reset, fetch_en=1, inst_ready=1, imem[i]=i*2: inst_valid rises 2nd cycle after
//    reset release; stream inst_pc=0,4,8.. with inst_out=0,2,4.. one per cycle, no gaps.
//  2 inst_ready=0 for 5 cycles: fq_count saturates at 2, pc stops at 8, head holds
//    pc=0/inst=0; release ready -> pcs 0,4,8,12 delivered in order, no loss/duplicate.
//  3 Redirect to 32'h0000_0103 at pc=0x10 with 2 queued: queue flushed same edge,
//    next delivered inst_pc=0x100, inst_out=imem[64]=128; no 0x10-range pc after it.
//  4 Redirect coincident with valid&ready and with fetch_en=0: flush wins, state IDLE,
//    inst_valid=0, pc=0x100 held until fetch_en=1.
//  5 pc=0x0000_0FFC -> next 0x1000, imem_addr wraps 1023->0; redirect 0xFFFF_FFFC:
//    next pc 0x0, no X on outputs.
//  6 Assert reset_n=0 for one cycle while full and stalled: all outputs at reset values
//    next cycle; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses imem and queues
// {pc, inst} pairs for decode behind a valid/ready handshake.
//
// Ports
//   clk            core clock, all state changes on the rising edge
//   reset_n        synchronous active-low reset
//   fetch_en       1 = fetch allowed, 0 = hold PC and stop pushing
//   redirect_valid one-cycle pulse: flush the queue, restart at redirect_pc
//   redirect_pc    new byte PC, low two bits dropped
//   imem_addr      imem word address, pc[IMEM_ADDR_WIDTH+1:2]
//   imem_dout      imem read data, combinational from imem_addr
//   inst_valid     queue head holds an instruction
//   inst_ready     decode takes the head when inst_valid is also high
//   inst_out       instruction word at the queue head
//   inst_pc        byte PC of inst_out
//   fq_count       queue occupancy, 0..FQ_DEPTH
module imem_fetch_ctrl #(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          FQ_DEPTH        = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_dout,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [31:0]                inst_out,
    output logic [31:0]                inst_pc,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pc_q;
    logic [31:0]   pc_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          flush;

    logic [31:0]   q_pc   [FQ_DEPTH];
    logic [31:0]   q_inst [FQ_DEPTH];

    // Low PC bits of a redirect target are discarded by design.
    logic          unused_rpc_bits;
    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign imem_addr  = pc_q[IMEM_ADDR_WIDTH+1:2];
    assign inst_valid = (count_q != '0);
    assign fq_count   = count_q;

    // Outputs come from queue storage only; an empty queue shows zeros
    // so stale or never-written slots are not visible.
    assign inst_out = inst_valid ? q_inst[rd_ptr] : 32'h0;
    assign inst_pc  = inst_valid ? q_pc[rd_ptr]   : 32'h0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            // Redirect beats everything: the pending pop is dropped
            // and nothing is pushed this cycle.
            flush   = 1'b1;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = fetch_en ? RUN : IDLE;
        end else begin
            pop = inst_valid & inst_ready;
            unique case (state_q)
                IDLE: begin
                    if (fetch_en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        state_d = IDLE;
                    end else if ((count_q < FULL) || pop) begin
                        // A pop frees the slot this cycle, so a full
                        // queue keeps streaming without a bubble.
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: slots are only read while counted valid.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            q_pc[wr_ptr]   <= pc_q;
            q_inst[wr_ptr] <= imem_dout;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: directed vector table plus randomized
// traffic against a queue-based reference model.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [1:0]  fq_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // imem[i] = i*2
    assign imem_dout = {21'b0, imem_addr, 1'b0};

    imem_fetch_ctrl #(
        .IMEM_ADDR_WIDTH(10),
        .RESET_PC(32'h0),
        .FQ_DEPTH(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_dout(imem_dout),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .fq_count(fq_count)
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h",
                     name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        fen;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic rst_n, input logic fen, input logic rv,
        input logic [31:0] rpc, input logic rdy, input logic ev,
        input logic [31:0] epc, input logic [31:0] einst,
        input logic [31:0] ecnt, input logic [31:0] eaddr);
        vec_t v;
        v.rst_n = rst_n; v.fen = fen; v.rv = rv; v.rpc = rpc;
        v.rdy = rdy; v.ev = ev; v.epc = epc; v.einst = einst;
        v.ecnt = ecnt; v.eaddr = eaddr;
        tbl.push_back(v);
    endfunction

    // Reference model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_pc;
    bit          m_run;
    bit          m_known;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {21'b0, pc[11:2], 1'b0};
    endfunction

    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (!reset_n) begin
            mq_pc.delete();
            mq_inst.delete();
            m_pc    = 32'h0;
            m_run   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (redirect_valid) begin
                mq_pc.delete();
                mq_inst.delete();
                m_pc  = redirect_pc & 32'hFFFF_FFFC;
                m_run = fetch_en;
            end else begin
                do_pop  = (mq_pc.size() > 0) && inst_ready;
                do_push = m_run && fetch_en &&
                          ((mq_pc.size() < 2) || do_pop);
                if (do_pop) begin
                    void'(mq_pc.pop_front());
                    void'(mq_inst.pop_front());
                end
                if (do_push) begin
                    mq_pc.push_back(m_pc);
                    mq_inst.push_back(mem_word(m_pc));
                    m_pc = m_pc + 32'd4;
                end
                m_run = fetch_en;
            end
        end
    endtask

    initial begin
        bit prev_rst;
        reset_n        = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        m_known        = 1'b0;
        m_run          = 1'b0;
        m_pc           = 32'h0;

        //  rst fen rv rpc            rdy  ev pc            inst  cnt addr
        add(0, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 0);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 0);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 0);
        add(1, 1, 0, 32'h0,           1,   1, 32'h0,        0,    1, 1);
        add(1, 1, 0, 32'h0,           1,   1, 32'h4,        2,    1, 2);
        add(1, 1, 0, 32'h0,           0,   1, 32'h8,        4,    1, 3);
        add(1, 1, 0, 32'h0,           0,   1, 32'h8,        4,    2, 4);
        add(1, 1, 0, 32'h0,           0,   1, 32'h8,        4,    2, 4);
        add(1, 1, 0, 32'h0,           0,   1, 32'h8,        4,    2, 4);
        add(1, 1, 0, 32'h0,           0,   1, 32'h8,        4,    2, 4);
        add(1, 1, 0, 32'h0,           1,   1, 32'h8,        4,    2, 4);
        add(1, 1, 0, 32'h0,           1,   1, 32'hC,        6,    2, 5);
        add(1, 1, 0, 32'h0,           1,   1, 32'h10,       8,    2, 6);
        add(1, 1, 1, 32'h103,         0,   1, 32'h14,       10,   2, 7);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 64);
        add(1, 1, 0, 32'h0,           1,   1, 32'h100,      128,  1, 65);
        add(1, 0, 1, 32'h100,         1,   1, 32'h104,      130,  1, 66);
        add(1, 0, 0, 32'h0,           1,   0, 32'h0,        0,    0, 64);
        add(1, 0, 0, 32'h0,           1,   0, 32'h0,        0,    0, 64);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 64);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 64);
        add(1, 1, 1, 32'hFF8,         1,   1, 32'h100,      128,  1, 65);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 1022);
        add(1, 1, 0, 32'h0,           1,   1, 32'hFF8,      2044, 1, 1023);
        add(1, 1, 0, 32'h0,           1,   1, 32'hFFC,      2046, 1, 0);
        add(1, 1, 1, 32'hFFFF_FFFE,   1,   1, 32'h1000,     0,    1, 1);
        add(1, 1, 0, 32'h0,           1,   0, 32'h0,        0,    0, 1023);
        add(1, 1, 0, 32'h0,           0,   1, 32'hFFFF_FFFC, 2046, 1, 0);
        add(1, 1, 0, 32'h0,           0,   1, 32'hFFFF_FFFC, 2046, 2, 1);
        add(0, 1, 0, 32'h0,           0,   1, 32'hFFFF_FFFC, 2046, 2, 1);
        add(1, 1, 0, 32'h0,           0,   0, 32'h0,        0,    0, 0);
        add(1, 1, 0, 32'h0,           0,   0, 32'h0,        0,    0, 0);
        add(1, 1, 0, 32'h0,           1,   1, 32'h0,        0,    1, 1);

        repeat (2) @(posedge clk);
        #1;

        // Directed table; data fields are checked when valid or just
        // out of reset (reset values are defined as zero).
        prev_rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            reset_n        = tbl[i].rst_n;
            fetch_en       = tbl[i].fen;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            inst_ready     = tbl[i].rdy;
            @(negedge clk);
            chk("vec_valid", i, {31'b0, inst_valid}, {31'b0, tbl[i].ev});
            chk("vec_count", i, {30'b0, fq_count}, tbl[i].ecnt);
            chk("vec_addr", i, {22'b0, imem_addr}, tbl[i].eaddr);
            if (tbl[i].ev || prev_rst) begin
                chk("vec_pc", i, inst_pc, tbl[i].epc);
                chk("vec_inst", i, inst_out, tbl[i].einst);
            end
            prev_rst = !tbl[i].rst_n;
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        m_known = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset_n        = (c == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
            fetch_en       = ($urandom_range(0, 99) < 85);
            redirect_valid = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else if ($urandom_range(0, 2) == 0)
                redirect_pc = 32'h0000_0FE0 | ($urandom & 32'h1F);
            else
                redirect_pc = $urandom;
            inst_ready     = ($urandom_range(0, 99) < 60);
            @(negedge clk);
            if (m_known) begin
                chk("rnd_valid", c, {31'b0, inst_valid},
                    {31'b0, (mq_pc.size() > 0)});
                chk("rnd_count", c, {30'b0, fq_count}, mq_pc.size());
                chk("rnd_addr", c, {22'b0, imem_addr}, {22'b0, m_pc[11:2]});
                if (mq_pc.size() > 0) begin
                    chk("rnd_pc", c, inst_pc, mq_pc[0]);
                    chk("rnd_inst", c, inst_out, mq_inst[0]);
                end
            end
            model_step();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
